nibble_serial_adder: RTL and testbench



---
 rtl/serial_add_pkg.sv | 17 +
 rtl/nibble_serial_adder_if.sv | 38 +++
 rtl/nibble_add_slice.sv | 14 +
 rtl/nibble_serial_adder.sv | 138 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the nibble-serial adder.
package serial_add_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of nibble steps needed for a given operand width.
    function automatic int unsigned nibbles(input int unsigned width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// With SERIAL_ADD_OVF_EN defined the bundle also carries the signed overflow flag.
interface nibble_serial_adder_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    // Operand source / result consumer side.
    modport master (
`ifdef SERIAL_ADD_OVF_EN
        input  ovf,
`endif
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, sum, co
    );

    // Adder side.
    modport slave (
`ifdef SERIAL_ADD_OVF_EN
        output ovf,
`endif
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, sum, co
    );

endinterface

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit full-adder slice: {co,s} = a + b + ci.
module nibble_add_slice
    import serial_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    assign {co, s} = (NIBBLE_W+1)'(a) + (NIBBLE_W+1)'(b) + (NIBBLE_W+1)'(ci);

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder: one shared 4-bit slice, LSB nibble first,
// ripple carry held in a register between nibbles.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed overflow flag (bus.ovf).
module nibble_serial_adder
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    nibble_serial_adder_if.slave bus,
    output logic                busy
);

    localparam int unsigned NIBBLES = nibbles(WIDTH);
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t               state_q, state_n;
    logic [IDX_W-1:0]     idx_q;
    logic [WIDTH-1:0]     a_q, b_q, sum_q;
    logic                 carry_q, co_q;
    logic                 in_ready_q, out_valid_q, busy_q;
    logic                 accept_c, step_c, last_c;
    logic [NIBBLE_W-1:0]  slice_s;
    logic                 slice_co;

    // Single shared slice, fed from the low nibble of the shifting operand registers.
    nibble_add_slice u_slice (
        .a  (a_q[NIBBLE_W-1:0]),
        .b  (b_q[NIBBLE_W-1:0]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // Next-state and datapath strobes.
    always_comb begin
        state_n  = state_q;
        accept_c = 1'b0;
        step_c   = 1'b0;
        last_c   = (idx_q == IDX_W'(NIBBLES - 1));
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    accept_c = 1'b1;
                    state_n  = ADD;
                end
            end
            ADD: begin
                step_c = 1'b1;
                if (last_c) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register; handshake/status flags are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            in_ready_q  <= (state_n == IDLE);
            out_valid_q <= (state_n == DONE);
            busy_q      <= (state_n != IDLE);
        end
    end

    // Operand capture, nibble stepping and result assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            idx_q   <= '0;
        end else if (accept_c) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.ci;
            sum_q   <= '0;
            co_q    <= 1'b0;
            idx_q   <= '0;
        end else if (step_c) begin
            a_q     <= a_q >> NIBBLE_W;
            b_q     <= b_q >> NIBBLE_W;
            carry_q <= slice_co;
            sum_q[idx_q*NIBBLE_W +: NIBBLE_W] <= slice_s;
            idx_q   <= idx_q + IDX_W'(1);
            if (last_c) begin
                co_q <= slice_co;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;
    logic msb_cin_c;

    // Carry into the MSB recovered from the slice's top bit: s3 = a3 ^ b3 ^ cin3.
    assign msb_cin_c = a_q[NIBBLE_W-1] ^ b_q[NIBBLE_W-1] ^ slice_s[NIBBLE_W-1];

    // Signed overflow, registered alongside the final nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (accept_c) begin
            ovf_q <= 1'b0;
        end else if (step_c && last_c) begin
            ovf_q <= msb_cin_c ^ slice_co;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.co        = co_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;

    localparam int unsigned W   = 16;
    localparam int          MAX = 20;

    logic clk;
    logic rst_n;
    logic busy;

    int n_vec = 0;
    int n_err = 0;

    nibble_serial_adder_if #(.WIDTH(W)) bus ();

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef SERIAL_ADD_OVF_EN
    logic last_ovf;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Present operands from IDLE and step through the accept edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        bus.a        = a;
        bus.b        = b;
        bus.ci       = ci;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    // Edges from the start of the accept cycle until out_valid is seen (bounded).
    task automatic wait_out(input string tag, output int lat);
        lat = 1;
        while (!bus.out_valid && lat < MAX) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_timeout"}, 32'(bus.out_valid), 32'd1);
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic [W-1:0] es, input logic ec);
        int lat;
        start_op(a, b, ci);
        check({tag, "_rdy_lo"}, 32'(bus.in_ready), 32'd0);
        wait_out(tag, lat);
        check({tag, "_lat"}, 32'(lat), 32'd5);
        check({tag, "_sum"}, 32'(bus.sum), 32'(es));
        check({tag, "_co"}, 32'(bus.co), 32'(ec));
        check({tag, "_busy"}, 32'(busy), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
        last_ovf = bus.ovf;
`endif
        @(posedge clk); #1;
        check({tag, "_vld_lo"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_rdy_hi"}, 32'(bus.in_ready), 32'd1);
    endtask

    logic [W-1:0] va [8];
    logic [W-1:0] vb [8];
    logic         vc [8];
    logic [W:0]   ve [8];
    int           lat, ni, no, cyc, last_cyc;
    logic         rdy;

    initial begin
        va[0] = 16'hA5A5; vb[0] = 16'h5A5A; vc[0] = 1'b0; ve[0] = 17'h0FFFF;
        va[1] = 16'hA5A5; vb[1] = 16'h5A5A; vc[1] = 1'b1; ve[1] = 17'h10000;
        va[2] = 16'h8000; vb[2] = 16'h8000; vc[2] = 1'b0; ve[2] = 17'h10000;
        va[3] = 16'h0F0F; vb[3] = 16'h0101; vc[3] = 1'b0; ve[3] = 17'h01010;
        va[4] = 16'h1111; vb[4] = 16'h2222; vc[4] = 1'b1; ve[4] = 17'h03334;
        va[5] = 16'hFFF0; vb[5] = 16'h0010; vc[5] = 1'b0; ve[5] = 17'h10000;
        va[6] = 16'h9999; vb[6] = 16'h6666; vc[6] = 1'b0; ve[6] = 17'h0FFFF;
        va[7] = 16'hC000; vb[7] = 16'h4001; vc[7] = 1'b1; ve[7] = 17'h10002;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ci        = 1'b0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_co", 32'(bus.co), 32'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic add, carry ripple through every nibble, and signed-overflow case.
        do_op("add_5555", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
        check("ripple_ovf", 32'(last_ovf), 32'd0);
`endif
        do_op("cin_8000", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
        check("cin_ovf", 32'(last_ovf), 32'd1);
`endif

        // Backpressure in DONE with a competing operand set on the input.
        bus.out_ready = 1'b0;
        start_op(16'h0ABC, 16'h1111, 1'b0);
        wait_out("bp", lat);
        check("bp_lat", 32'(lat), 32'd5);
        check("bp_sum0", 32'(bus.sum), 32'h1BCD);
        bus.a        = 16'hFFFF;
        bus.b        = 16'hFFFF;
        bus.ci       = 1'b0;
        bus.in_valid = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check("bp_hold_vld", 32'(bus.out_valid), 32'd1);
            check("bp_hold_sum", 32'(bus.sum), 32'h1BCD);
            check("bp_hold_co", 32'(bus.co), 32'd0);
            check("bp_hold_rdy", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_hs_vld", 32'(bus.out_valid), 32'd0);
        check("bp_hs_rdy", 32'(bus.in_ready), 32'd1);
        check("bp_hs_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("bp_acc_rdy", 32'(bus.in_ready), 32'd0);
        check("bp_acc_busy", 32'(busy), 32'd1);
        wait_out("bp2", lat);
        check("bp2_sum", 32'(bus.sum), 32'hFFFE);
        check("bp2_co", 32'(bus.co), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
        check("bp2_ovf", 32'(bus.ovf), 32'd0);
`endif
        @(posedge clk); #1;

        // Asynchronous reset while nibble 2 is in flight.
        start_op(16'h1234, 16'h4321, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_partial", 32'(bus.sum), 32'h0055);
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld", 32'(bus.out_valid), 32'd0);
        check("mid_rst_sum", 32'(bus.sum), 32'd0);
        check("mid_rst_rdy", 32'(bus.in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_vld", 32'(bus.out_valid), 32'd0);
        do_op("post_rst", 16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0);

        // Back-to-back with in_valid held high.
        ni = 0;
        no = 0;
        cyc = 0;
        last_cyc = 0;
        bus.a        = va[0];
        bus.b        = vb[0];
        bus.ci       = vc[0];
        bus.in_valid = 1'b1;
        rdy = bus.in_ready;
        while (no < 8 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (rdy && bus.in_valid) begin
                ni++;
                if (ni < 8) begin
                    bus.a  = va[ni];
                    bus.b  = vb[ni];
                    bus.ci = vc[ni];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.out_valid) begin
                check("b2b_res", 32'({bus.co, bus.sum}), 32'(ve[no]));
                if (no > 0) begin
                    check("b2b_period", 32'(cyc - last_cyc), 32'd6);
                end
                last_cyc = cyc;
                no++;
            end
            rdy = bus.in_ready;
        end
        check("b2b_count", 32'(no), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
